// File: rtl/ram_ctrl_pkg.sv
// Shared sizes for the A501 DRAM-to-SRAM bridge.
// ROW_W: multiplexed address width; ADDR_W: rebuilt SRAM address width.
package ram_ctrl_pkg;
  localparam int ROW_W  = 9;
  localparam int ADDR_W = 2 * ROW_W;
endpackage

// File: rtl/ram_ctrl_sync.sv
// N-stage synchronizer for asynchronous inputs, parameterized width.
// Ports: clk, rst (sync, high), d (async in), q (synced out, RST_VAL on reset).
module ram_ctrl_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stg_q [STAGES];
  logic [W-1:0] stg_d [STAGES];

  always_comb begin
    stg_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  assign q = stg_q[STAGES-1];
endmodule

// File: rtl/ram_controller.sv
// Amiga multiplexed-DRAM bus to flat SRAM control (A501 expansion).
// In: clk, rst, Ain, OEin_n, CASU_n, CASL_n, WE_n, RAS_n (async). Out: Aout, OEout_n, UB_n, LB_n, CE_n.
module ram_controller
  import ram_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  Ain,
  input  logic              OEin_n,
  input  logic              CASU_n,
  input  logic              CASL_n,
  input  logic              WE_n,
  input  logic              RAS_n,
  output logic [ADDR_W-1:0] Aout,
  output logic              OEout_n,
  output logic              UB_n,
  output logic              LB_n,
  output logic              CE_n
);
  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [4:0]       strb_s;
  logic [ROW_W-1:0] ain_s;
  logic ras_s, casu_s, casl_s, we_s, oe_s;

  ram_ctrl_sync #(
    .W(5), .STAGES(SYNC_STAGES), .RST_VAL(5'h1F)
  ) u_sync_strb (
    .clk(clk), .rst(rst),
    .d({RAS_n, CASU_n, CASL_n, WE_n, OEin_n}),
    .q(strb_s)
  );

  ram_ctrl_sync #(
    .W(ROW_W), .STAGES(SYNC_STAGES), .RST_VAL('0)
  ) u_sync_ain (
    .clk(clk), .rst(rst), .d(Ain), .q(ain_s)
  );

  assign {ras_s, casu_s, casl_s, we_s, oe_s} = strb_s;

  logic ras_prev_q, casu_prev_q, casl_prev_q;
  logic active_q, active_d;
  logic refresh_q, refresh_d;
  logic armed_q, armed_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [ROW_W-1:0] row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] aout_q, aout_d;
  logic oe_n_q, oe_n_d, ub_n_q, ub_n_d;
  logic lb_n_q, lb_n_d, ce_n_q, ce_n_d;
  logic ras_fall, ras_rise, cas_fall, cas_idle_prev, settled;

  always_comb begin
    settled  = (fill_q == CW'(SYNC_STAGES));
    fill_d   = settled ? fill_q : fill_q + 1'b1;
    // A strobe still held low across reset must not look like a
    // new access: only arm once RAS has really been seen high.
    armed_d  = armed_q | (settled & ras_s);
    ras_fall = armed_q & ras_prev_q & ~ras_s;
    ras_rise = ~ras_prev_q & ras_s;
    cas_idle_prev = casu_prev_q & casl_prev_q;
    cas_fall = cas_idle_prev & (~casu_s | ~casl_s);

    row_d     = row_q;
    col_d     = col_q;
    active_d  = active_q;
    refresh_d = refresh_q;

    if (ras_rise) begin
      active_d  = 1'b0;
      refresh_d = 1'b0;
    end else if (ras_fall) begin
      // CAS state before this sample decides CBR; a CAS fall in the
      // same sample as RAS fall is still a normal access.
      if (cas_idle_prev) begin
        row_d    = ain_s;
        active_d = 1'b1;
      end else begin
        refresh_d = 1'b1;
        active_d  = 1'b0;
      end
    end else if (cas_fall && active_q) begin
      col_d = ain_s;
    end

    // Outputs use next-state values to hold latency at SYNC_STAGES+1.
    aout_d = {col_d, row_d};
    ce_n_d = ~active_d;
    ub_n_d = ~(active_d & ~casu_s);
    lb_n_d = ~(active_d & ~casl_s);
    oe_n_d = ~(active_d & ~oe_s & we_s & (~casu_s | ~casl_s));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_prev_q  <= 1'b1;
      casu_prev_q <= 1'b1;
      casl_prev_q <= 1'b1;
      active_q    <= 1'b0;
      refresh_q   <= 1'b0;
      armed_q     <= 1'b0;
      fill_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      aout_q      <= '0;
      oe_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
    end else begin
      ras_prev_q  <= ras_s;
      casu_prev_q <= casu_s;
      casl_prev_q <= casl_s;
      active_q    <= active_d;
      refresh_q   <= refresh_d;
      armed_q     <= armed_d;
      fill_q      <= fill_d;
      row_q       <= row_d;
      col_q       <= col_d;
      aout_q      <= aout_d;
      oe_n_q      <= oe_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      ce_n_q      <= ce_n_d;
    end
  end

  assign Aout    = aout_q;
  assign OEout_n = oe_n_q;
  assign UB_n    = ub_n_q;
  assign LB_n    = lb_n_q;
  assign CE_n    = ce_n_q;
endmodule

// File: tb/tb_ram_controller.sv
// Directed self-checking bench for ram_controller.
// Each task drives one scenario and compares outputs with hand-computed values.
module tb_ram_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  Ain = '0;
  logic        OEin_n = 1'b1;
  logic        CASU_n = 1'b1;
  logic        CASL_n = 1'b1;
  logic        WE_n = 1'b1;
  logic        RAS_n = 1'b1;
  logic [17:0] Aout;
  logic        OEout_n, UB_n, LB_n, CE_n;

  int checks = 0;
  int errors = 0;

  ram_controller dut (
    .clk(clk), .rst(rst), .Ain(Ain),
    .OEin_n(OEin_n), .CASU_n(CASU_n), .CASL_n(CASL_n),
    .WE_n(WE_n), .RAS_n(RAS_n), .Aout(Aout),
    .OEout_n(OEout_n), .UB_n(UB_n), .LB_n(LB_n), .CE_n(CE_n)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n, OEout_n} !== {18'h00000, 4'b1111}) begin
      errors++;
      $display("FAIL reset: got Aout=%h ce/ub/lb/oe=%b%b%b%b want 00000 1111",
               Aout, CE_n, UB_n, LB_n, OEout_n);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_read;
    Ain = 9'h0AF; RAS_n = 1'b0;
    tick(3);
    checks++;
    if (CE_n !== 1'b0 || Aout !== 18'h000AF) begin
      errors++;
      $display("FAIL ras_fall: got CE_n=%b Aout=%h want 0 000AF", CE_n, Aout);
    end
    Ain = 9'h09A; CASU_n = 1'b0; CASL_n = 1'b0; OEin_n = 1'b0;
    tick(2);
    checks++;
    if (UB_n !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: got UB_n=%b want 1", UB_n);
    end
    tick(1);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n, OEout_n} !== {18'h134AF, 4'b0000}) begin
      errors++;
      $display("FAIL read: got Aout=%h ce/ub/lb/oe=%b%b%b%b want 134AF 0000",
               Aout, CE_n, UB_n, LB_n, OEout_n);
    end
  endtask

  task automatic test_page_mode;
    CASU_n = 1'b1; CASL_n = 1'b1;
    tick(3);
    checks++;
    if ({CE_n, UB_n, LB_n, OEout_n} !== 4'b0111) begin
      errors++;
      $display("FAIL cas_rise: got ce/ub/lb/oe=%b%b%b%b want 0111",
               CE_n, UB_n, LB_n, OEout_n);
    end
    Ain = 9'h09B; CASU_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n} !== {18'h136AF, 3'b001}) begin
      errors++;
      $display("FAIL page1: got Aout=%h ce/ub/lb=%b%b%b want 136AF 001",
               Aout, CE_n, UB_n, LB_n);
    end
    CASU_n = 1'b1;
    tick(3);
    Ain = 9'h09C; CASU_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n} !== {18'h138AF, 3'b001}) begin
      errors++;
      $display("FAIL page2: got Aout=%h ce/ub/lb=%b%b%b want 138AF 001",
               Aout, CE_n, UB_n, LB_n);
    end
    CASU_n = 1'b1;
    tick(3);
  endtask

  task automatic test_write;
    WE_n = 1'b0; OEin_n = 1'b0; Ain = 9'h09C;
    CASU_n = 1'b0; CASL_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n, OEout_n} !== {18'h138AF, 4'b0001}) begin
      errors++;
      $display("FAIL write: got Aout=%h ce/ub/lb/oe=%b%b%b%b want 138AF 0001",
               Aout, CE_n, UB_n, LB_n, OEout_n);
    end
    WE_n = 1'b1;
    tick(3);
  endtask

  task automatic test_ras_rise;
    RAS_n = 1'b1;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n, OEout_n} !== {18'h138AF, 4'b1111}) begin
      errors++;
      $display("FAIL ras_rise: got Aout=%h ce/ub/lb/oe=%b%b%b%b want 138AF 1111",
               Aout, CE_n, UB_n, LB_n, OEout_n);
    end
    CASU_n = 1'b1; CASL_n = 1'b1; OEin_n = 1'b1;
    tick(3);
  endtask

  task automatic test_refresh;
    CASL_n = 1'b0; OEin_n = 1'b0;
    tick(3);
    Ain = 9'h1FF; RAS_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n, OEout_n} !== {18'h138AF, 4'b1111}) begin
      errors++;
      $display("FAIL cbr: got Aout=%h ce/ub/lb/oe=%b%b%b%b want 138AF 1111",
               Aout, CE_n, UB_n, LB_n, OEout_n);
    end
    RAS_n = 1'b1; CASL_n = 1'b1; OEin_n = 1'b1;
    tick(3);
  endtask

  task automatic test_simul_ras_cas;
    Ain = 9'h055; RAS_n = 1'b0; CASU_n = 1'b0; CASL_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n} !== {18'h13855, 1'b0}) begin
      errors++;
      $display("FAIL simul_fall: got Aout=%h CE_n=%b want 13855 0", Aout, CE_n);
    end
    CASU_n = 1'b1; CASL_n = 1'b1;
    tick(3);
    Ain = 9'h011; CASU_n = 1'b0; CASL_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n} !== {18'h02255, 3'b000}) begin
      errors++;
      $display("FAIL simul_next_cas: got Aout=%h ce/ub/lb=%b%b%b want 02255 000",
               Aout, CE_n, UB_n, LB_n);
    end
    CASU_n = 1'b1; CASL_n = 1'b1;
    tick(3);
  endtask

  task automatic test_rise_beats_cas;
    Ain = 9'h1AA; RAS_n = 1'b1; CASU_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, UB_n} !== {18'h02255, 2'b11}) begin
      errors++;
      $display("FAIL rise_vs_cas: got Aout=%h ce/ub=%b%b want 02255 11",
               Aout, CE_n, UB_n);
    end
    CASU_n = 1'b1;
    tick(3);
  endtask

  task automatic test_reset_mid_access;
    Ain = 9'h0F0; RAS_n = 1'b0;
    tick(3);
    Ain = 9'h003; CASU_n = 1'b0; CASL_n = 1'b0; OEin_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n, OEout_n} !== {18'h006F0, 2'b00}) begin
      errors++;
      $display("FAIL pre_rst_access: got Aout=%h ce/oe=%b%b want 006F0 00",
               Aout, CE_n, OEout_n);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({Aout, CE_n, UB_n, LB_n, OEout_n} !== {18'h00000, 4'b1111}) begin
      errors++;
      $display("FAIL rst_mid: got Aout=%h ce/ub/lb/oe=%b%b%b%b want 00000 1111",
               Aout, CE_n, UB_n, LB_n, OEout_n);
    end
    rst = 1'b0;
    tick(6);
    checks++;
    if ({CE_n, UB_n, OEout_n} !== 3'b111) begin
      errors++;
      $display("FAIL no_stale_access: got ce/ub/oe=%b%b%b want 111",
               CE_n, UB_n, OEout_n);
    end
    RAS_n = 1'b1; CASU_n = 1'b1; CASL_n = 1'b1; OEin_n = 1'b1;
    tick(4);
    Ain = 9'h010; RAS_n = 1'b0;
    tick(3);
    checks++;
    if ({Aout, CE_n} !== {18'h00010, 1'b0}) begin
      errors++;
      $display("FAIL fresh_access: got Aout=%h CE_n=%b want 00010 0", Aout, CE_n);
    end
    RAS_n = 1'b1;
    tick(3);
  endtask

  initial begin
    tick(1);
    test_reset;
    test_read;
    test_page_mode;
    test_write;
    test_ras_rise;
    test_refresh;
    test_simul_ras_cas;
    test_rise_beats_cas;
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
